// File: rtl/sched_controller.sv
// rtl/sched_controller.sv - scheduler: handler vectors, preemption timer, interrupt arbitration
//
// Purpose:
//   Consumes decoded scheduler ops and holds the syscall, timer and DMA handler
//   vectors. Runs the preemption down-counter and arbitrates pending events
//   into a single interrupt request toward fetch. Saves the interrupted PC and
//   returns it on RETR.
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   SCHED_conf      in   op strobe, one op per cycle when high
//   SCHED_OP        in   op code (SYSCFG/TMRCFG/DMACFG/START/RTIMER/RETR/PC)
//   SCHED_value     in   op operand (vector address or quantum)
//   PC_pos          in   PC of the instruction in execute
//   SYS_trap        in   syscall trap pulse
//   DMA_done        in   DMA completion pulse
//   INT_ack         in   fetch has redirected to INT_vector
//   INT_req         out  interrupt request, held until acked
//   INT_vector      out  handler address for INT_req
//   SCHED_out       out  result of RETR/PC op, held between ops
//   SCHED_out_valid out  one-cycle qualifier for SCHED_out
//   SCHED_active    out  high whenever the scheduler is not IDLE
module sched_controller #(
    parameter int PC_W  = 16,
    parameter int TMR_W = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            SCHED_conf,
    input  logic [3:0]      SCHED_OP,
    input  logic [15:0]     SCHED_value,
    input  logic [PC_W-1:0] PC_pos,
    input  logic            SYS_trap,
    input  logic            DMA_done,
    input  logic            INT_ack,
    output logic            INT_req,
    output logic [PC_W-1:0] INT_vector,
    output logic [PC_W-1:0] SCHED_out,
    output logic            SCHED_out_valid,
    output logic            SCHED_active
);

    localparam logic [3:0] OP_SYSCFG = 4'b0001;
    localparam logic [3:0] OP_TMRCFG = 4'b0010;
    localparam logic [3:0] OP_DMACFG = 4'b0011;
    localparam logic [3:0] OP_START  = 4'b0100;
    localparam logic [3:0] OP_RTIMER = 4'b0101;
    localparam logic [3:0] OP_RETR   = 4'b0110;
    localparam logic [3:0] OP_PC     = 4'b0111;

    localparam logic [1:0] WIN_SYS = 2'd0;
    localparam logic [1:0] WIN_DMA = 2'd1;
    localparam logic [1:0] WIN_TMR = 2'd2;

    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_TAKE    = 2'd2,
        ST_HANDLER = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [PC_W-1:0]   sys_vec_q,  sys_vec_d;
    logic [PC_W-1:0]   tmr_vec_q,  tmr_vec_d;
    logic [PC_W-1:0]   dma_vec_q,  dma_vec_d;
    logic              sys_v_q,    sys_v_d;
    logic              tmr_v_q,    tmr_v_d;
    logic              dma_v_q,    dma_v_d;
    logic [TMR_W-1:0]  quantum_q,  quantum_d;
    logic [TMR_W-1:0]  counter_q,  counter_d;
    logic [PC_W-1:0]   last_pc_q,  last_pc_d;
    logic              sys_pend_q, sys_pend_d;
    logic              dma_pend_q, dma_pend_d;
    logic              tmr_pend_q, tmr_pend_d;
    logic [1:0]        win_q,      win_d;
    logic              int_req_q,  int_req_d;
    logic [PC_W-1:0]   int_vec_q,  int_vec_d;
    logic [PC_W-1:0]   out_q,      out_d;
    logic              out_vld_q,  out_vld_d;

    // Operand resized to the PC and timer widths (truncate or zero-extend).
    logic [PC_W-1:0]   val_pc;
    logic [TMR_W-1:0]  val_tmr;

    generate
        if (PC_W > 16) begin : g_pc_ext
            assign val_pc = {{(PC_W-16){1'b0}}, SCHED_value};
        end else begin : g_pc_trunc
            assign val_pc = SCHED_value[PC_W-1:0];
        end
        if (TMR_W > 16) begin : g_tmr_ext
            assign val_tmr = {{(TMR_W-16){1'b0}}, SCHED_value};
        end else begin : g_tmr_trunc
            assign val_tmr = SCHED_value[TMR_W-1:0];
        end
    endgenerate

    logic op_syscfg, op_tmrcfg, op_dmacfg, op_start, op_rtimer, op_retr, op_pc;
    logic timer_fire;

    assign op_syscfg = SCHED_conf && (SCHED_OP == OP_SYSCFG);
    assign op_tmrcfg = SCHED_conf && (SCHED_OP == OP_TMRCFG);
    assign op_dmacfg = SCHED_conf && (SCHED_OP == OP_DMACFG);
    assign op_start  = SCHED_conf && (SCHED_OP == OP_START);
    assign op_rtimer = SCHED_conf && (SCHED_OP == OP_RTIMER);
    assign op_retr   = SCHED_conf && (SCHED_OP == OP_RETR);
    assign op_pc     = SCHED_conf && (SCHED_OP == OP_PC);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sys_vec_q  <= '0;
            tmr_vec_q  <= '0;
            dma_vec_q  <= '0;
            sys_v_q    <= 1'b0;
            tmr_v_q    <= 1'b0;
            dma_v_q    <= 1'b0;
            quantum_q  <= '0;
            counter_q  <= '0;
            last_pc_q  <= '0;
            sys_pend_q <= 1'b0;
            dma_pend_q <= 1'b0;
            tmr_pend_q <= 1'b0;
            win_q      <= WIN_SYS;
            int_req_q  <= 1'b0;
            int_vec_q  <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sys_vec_q  <= sys_vec_d;
            tmr_vec_q  <= tmr_vec_d;
            dma_vec_q  <= dma_vec_d;
            sys_v_q    <= sys_v_d;
            tmr_v_q    <= tmr_v_d;
            dma_v_q    <= dma_v_d;
            quantum_q  <= quantum_d;
            counter_q  <= counter_d;
            last_pc_q  <= last_pc_d;
            sys_pend_q <= sys_pend_d;
            dma_pend_q <= dma_pend_d;
            tmr_pend_q <= tmr_pend_d;
            win_q      <= win_d;
            int_req_q  <= int_req_d;
            int_vec_q  <= int_vec_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sys_vec_d  = sys_vec_q;
        tmr_vec_d  = tmr_vec_q;
        dma_vec_d  = dma_vec_q;
        sys_v_d    = sys_v_q;
        tmr_v_d    = tmr_v_q;
        dma_v_d    = dma_v_q;
        quantum_d  = quantum_q;
        counter_d  = counter_q;
        last_pc_d  = last_pc_q;
        sys_pend_d = sys_pend_q;
        dma_pend_d = dma_pend_q;
        tmr_pend_d = tmr_pend_q;
        win_d      = win_q;
        int_req_d  = int_req_q;
        int_vec_d  = int_vec_q;
        out_d      = out_q;
        out_vld_d  = 1'b0;
        timer_fire = 1'b0;

        // Vector configuration
        if (op_syscfg) begin
            sys_vec_d = val_pc;
            sys_v_d   = 1'b1;
        end
        if (op_tmrcfg) begin
            tmr_vec_d = val_pc;
            tmr_v_d   = 1'b1;
        end
        if (op_dmacfg) begin
            dma_vec_d = val_pc;
            dma_v_d   = 1'b1;
        end

        // Preemption timer; reloading at 1 gives a period of exactly quantum
        // cycles and keeps the counter from ever reaching 0.
        if (state_q == ST_RUN && quantum_q != '0) begin
            if (counter_q <= TMR_ONE) begin
                counter_d  = quantum_q;
                timer_fire = 1'b1;
            end else begin
                counter_d = counter_q - TMR_ONE;
            end
        end
        if (op_rtimer && state_q != ST_IDLE) begin
            counter_d = quantum_q;
        end

        // State machine; ack clears happen before new events are merged so
        // an event arriving with the ack is still recorded.
        case (state_q)
            ST_RUN: begin
                if (sys_pend_q || dma_pend_q || tmr_pend_q) begin
                    state_d   = ST_TAKE;
                    int_req_d = 1'b1;
                    last_pc_d = PC_pos;
                    if (sys_pend_q) begin
                        win_d     = WIN_SYS;
                        int_vec_d = sys_vec_q;
                    end else if (dma_pend_q) begin
                        win_d     = WIN_DMA;
                        int_vec_d = dma_vec_q;
                    end else begin
                        win_d     = WIN_TMR;
                        int_vec_d = tmr_vec_q;
                    end
                end
            end
            ST_TAKE: begin
                if (INT_ack && int_req_q) begin
                    state_d   = ST_HANDLER;
                    int_req_d = 1'b0;
                    case (win_q)
                        WIN_SYS: sys_pend_d = 1'b0;
                        WIN_DMA: dma_pend_d = 1'b0;
                        default: tmr_pend_d = 1'b0;
                    endcase
                end
            end
            ST_HANDLER: begin
                if (op_retr) begin
                    state_d   = ST_RUN;
                    counter_d = quantum_q;
                end
            end
            default: ;
        endcase

        // Event capture; nothing is recorded while IDLE.
        if (state_q != ST_IDLE) begin
            if (SYS_trap && sys_v_q) sys_pend_d = 1'b1;
            if (DMA_done && dma_v_q) dma_pend_d = 1'b1;
            if (timer_fire && tmr_v_q) tmr_pend_d = 1'b1;
        end

        // START overrides everything else, including an outstanding request.
        if (op_start) begin
            quantum_d  = val_tmr;
            counter_d  = val_tmr;
            sys_pend_d = 1'b0;
            dma_pend_d = 1'b0;
            tmr_pend_d = 1'b0;
            int_req_d  = 1'b0;
            state_d    = ST_RUN;
        end

        if (op_retr) begin
            out_d     = last_pc_q;
            out_vld_d = 1'b1;
        end
        if (op_pc) begin
            out_d     = PC_pos;
            out_vld_d = 1'b1;
        end
    end

    assign INT_req         = int_req_q;
    assign INT_vector      = int_vec_q;
    assign SCHED_out       = out_q;
    assign SCHED_out_valid = out_vld_q;
    assign SCHED_active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sched_controller.sv
// tb/tb_sched_controller.sv - directed self-checking bench for sched_controller
module tb_sched_controller;

    localparam logic [3:0] OP_SYSCFG = 4'b0001;
    localparam logic [3:0] OP_TMRCFG = 4'b0010;
    localparam logic [3:0] OP_DMACFG = 4'b0011;
    localparam logic [3:0] OP_START  = 4'b0100;
    localparam logic [3:0] OP_RTIMER = 4'b0101;
    localparam logic [3:0] OP_RETR   = 4'b0110;
    localparam logic [3:0] OP_PC     = 4'b0111;

    logic        clock;
    logic        reset;
    logic        SCHED_conf;
    logic [3:0]  SCHED_OP;
    logic [15:0] SCHED_value;
    logic [15:0] PC_pos;
    logic        SYS_trap;
    logic        DMA_done;
    logic        INT_ack;
    logic        INT_req;
    logic [15:0] INT_vector;
    logic [15:0] SCHED_out;
    logic        SCHED_out_valid;
    logic        SCHED_active;

    int n_pass  = 0;
    int n_total = 0;
    logic seen;

    sched_controller #(.PC_W(16), .TMR_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .SCHED_conf     (SCHED_conf),
        .SCHED_OP       (SCHED_OP),
        .SCHED_value    (SCHED_value),
        .PC_pos         (PC_pos),
        .SYS_trap       (SYS_trap),
        .DMA_done       (DMA_done),
        .INT_ack        (INT_ack),
        .INT_req        (INT_req),
        .INT_vector     (INT_vector),
        .SCHED_out      (SCHED_out),
        .SCHED_out_valid(SCHED_out_valid),
        .SCHED_active   (SCHED_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its end (observed running, required finished)");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic [3:0] code, input logic [15:0] val);
        SCHED_conf  = 1'b1;
        SCHED_OP    = code;
        SCHED_value = val;
        tick();
        SCHED_conf  = 1'b0;
        SCHED_OP    = 4'b0000;
        SCHED_value = 16'h0000;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset       = 1'b1;
        SCHED_conf  = 1'b0;
        SCHED_OP    = 4'b0000;
        SCHED_value = 16'h0000;
        PC_pos      = 16'h0000;
        SYS_trap    = 1'b0;
        DMA_done    = 1'b0;
        INT_ack     = 1'b0;
        tick();
        tick();
        chk1 ("rst_int_req", INT_req, 1'b0);
        chk16("rst_int_vec", INT_vector, 16'h0000);
        chk16("rst_out", SCHED_out, 16'h0000);
        chk1 ("rst_out_valid", SCHED_out_valid, 1'b0);
        chk1 ("rst_active", SCHED_active, 1'b0);
        reset = 1'b0;
        tick();

        // Timer interrupt: quantum 5, request 6 cycles after START.
        op(OP_TMRCFG, 16'h0200);
        PC_pos = 16'h1234;
        op(OP_START, 16'd5);
        chk1("start_active", SCHED_active, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk1("tmr_not_yet", INT_req, 1'b0);
        tick();
        PC_pos = 16'h5555;
        chk1 ("tmr_req", INT_req, 1'b1);
        chk16("tmr_vec", INT_vector, 16'h0200);
        tick();
        tick();
        chk1 ("tmr_req_held", INT_req, 1'b1);
        chk16("tmr_vec_held", INT_vector, 16'h0200);
        INT_ack = 1'b1;
        tick();
        INT_ack = 1'b0;
        chk1("tmr_ack_drop", INT_req, 1'b0);
        op(OP_RETR, 16'h0000);
        chk16("retr_out", SCHED_out, 16'h1234);
        chk1 ("retr_valid", SCHED_out_valid, 1'b1);
        tick();
        chk1 ("retr_valid_pulse", SCHED_out_valid, 1'b0);
        chk16("retr_out_hold", SCHED_out, 16'h1234);
        for (int i = 0; i < 4; i++) tick();
        chk1("tmr2_not_yet", INT_req, 1'b0);
        tick();
        chk1("tmr2_req", INT_req, 1'b1);

        // Asynchronous reset while a request is outstanding.
        #2;
        reset = 1'b1;
        #1;
        chk1 ("arst_int_req", INT_req, 1'b0);
        chk16("arst_int_vec", INT_vector, 16'h0000);
        chk16("arst_out", SCHED_out, 16'h0000);
        chk1 ("arst_active", SCHED_active, 1'b0);
        tick();
        reset = 1'b0;
        op(OP_SYSCFG, 16'h0100);
        SYS_trap = 1'b1;
        tick();
        SYS_trap = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk1("idle_trap_ignored", INT_req, 1'b0);
        chk1("idle_still", SCHED_active, 1'b0);

        // Simultaneous syscall and DMA: sys wins, dma follows after RETR.
        op(OP_DMACFG, 16'h0300);
        op(OP_START, 16'd100);
        PC_pos   = 16'h0AAA;
        SYS_trap = 1'b1;
        DMA_done = 1'b1;
        tick();
        SYS_trap = 1'b0;
        DMA_done = 1'b0;
        chk1("pri_not_yet", INT_req, 1'b0);
        tick();
        chk1 ("pri_req", INT_req, 1'b1);
        chk16("pri_vec_sys", INT_vector, 16'h0100);
        INT_ack = 1'b1;
        tick();
        INT_ack = 1'b0;
        chk1("pri_ack", INT_req, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk1("handler_masked", INT_req, 1'b0);
        op(OP_RETR, 16'h0000);
        chk16("pri_retr_out", SCHED_out, 16'h0AAA);
        chk1 ("pri_retr_noreq", INT_req, 1'b0);
        tick();
        chk1 ("pri_req2", INT_req, 1'b1);
        chk16("pri_vec_dma", INT_vector, 16'h0300);
        INT_ack = 1'b1;
        tick();
        INT_ack = 1'b0;

        // DMA without a configured vector, PC op, and quantum 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        op(OP_TMRCFG, 16'h0200);
        op(OP_START, 16'd0);
        DMA_done = 1'b1;
        tick();
        DMA_done = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk1("dma_unconfigured", INT_req, 1'b0);
        PC_pos = 16'h0042;
        op(OP_PC, 16'h0000);
        chk16("pc_out", SCHED_out, 16'h0042);
        chk1 ("pc_valid", SCHED_out_valid, 1'b1);
        tick();
        chk1 ("pc_valid_pulse", SCHED_out_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (INT_req) seen = 1'b1;
        end
        chk1("quantum0_no_int", seen, 1'b0);

        // RTIMER every third cycle keeps a quantum-4 timer from firing.
        op(OP_START, 16'd4);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (INT_req) seen = 1'b1;
            tick();
            if (INT_req) seen = 1'b1;
            op(OP_RTIMER, 16'h0000);
            if (INT_req) seen = 1'b1;
        end
        chk1("rtimer_no_int", seen, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk1("rtimer_stop_not_yet", INT_req, 1'b0);
        tick();
        chk1("rtimer_stop_req", INT_req, 1'b1);
        INT_ack = 1'b1;
        tick();
        INT_ack = 1'b0;

        // HANDLER: timer frozen, syscall held until RETR.
        op(OP_SYSCFG, 16'h0100);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            SYS_trap = (i == 10);
            tick();
            if (INT_req) seen = 1'b1;
        end
        SYS_trap = 1'b0;
        chk1("handler_50_no_int", seen, 1'b0);
        op(OP_RETR, 16'h0000);
        chk1("handler_retr_noreq", INT_req, 1'b0);
        tick();
        chk1 ("handler_sys_req", INT_req, 1'b1);
        chk16("handler_sys_vec", INT_vector, 16'h0100);
        op(OP_START, 16'd0);
        chk1("start_in_take_drops", INT_req, 1'b0);
        chk1("start_in_take_active", SCHED_active, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sched_controller.md
Name: sched_controller

Overview:
- Stateful scheduler that consumes the config strobes produced by the scheduler decoder (SCHED_conf/SCHED_OP/SCHED_value).
- Holds the syscall, timer and DMA handler vectors and runs the preemption timer.
- Arbitrates interrupt requests to the fetch stage, saves the interrupted PC, and returns it on RETR.
- Sits between the decoder and the PC/fetch logic.

Parameters:
- PC_W, 16, width of PC, vectors and saved PC
- TMR_W, 16, width of quantum register and down-counter

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- SCHED_conf  in  1  op strobe from decoder, one op per cycle when high
- SCHED_OP  in  4  op code: 0001 SYSCFG, 0010 TMRCFG, 0011 DMACFG, 0100 START, 0101 RTIMER, 0110 RETR, 0111 PC
- SCHED_value  in  16  op operand (vector address / quantum)
- PC_pos  in  PC_W  PC of the instruction currently in execute
- SYS_trap  in  1  one-cycle syscall trap pulse
- DMA_done  in  1  one-cycle DMA completion pulse
- INT_ack  in  1  fetch has redirected to INT_vector
- INT_req  out  1  interrupt request, held until acked
- INT_vector  out  PC_W  handler address for INT_req
- SCHED_out  out  PC_W  result of RETR/PC op
- SCHED_out_valid  out  1  one-cycle qualifier for SCHED_out
- SCHED_active  out  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high.
- Reset values:
  - Outputs: all outputs 0.
  - State: IDLE.
  - Registers: vectors, quantum, counter, last_pc and pending bits all 0; vector-valid bits sys_v, tmr_v, dma_v = 0.
- Reset mid-operation: aborts any request immediately, with no ack needed.
- Config ops (SCHED_conf=1), all registered at the clock edge and visible next cycle:
  - SYSCFG/TMRCFG/DMACFG: write the vector from SCHED_value[PC_W-1:0] and set the matching valid bit. Legal in any state.
  - START: quantum<=value, counter<=value, clear all pending bits, state<=RUN. Legal in any state, including TAKE, which drops INT_req.
  - RTIMER: counter<=quantum. Ignored in IDLE.
  - RETR: SCHED_out<=last_pc, SCHED_out_valid=1 the next cycle. If state==HANDLER, also state<=RUN and counter<=quantum.
  - PC: SCHED_out<=PC_pos, SCHED_out_valid=1 the next cycle.
  - Any other op: no effect.
  - SCHED_out holds its value between ops; SCHED_out_valid is a 1-cycle pulse.
- Timer:
  - Counter decrements by 1 per cycle only in RUN, and only when quantum!=0.
  - When counter==1 and decrementing: set tmr_pend and reload counter<=quantum (period = quantum cycles).
  - quantum==0 disables the timer.
  - RTIMER takes priority over the decrement in the same cycle.
- Pending bits:
  - SYS_trap sets sys_pend if sys_v; DMA_done sets dma_pend if dma_v; timer expiry sets tmr_pend if tmr_v.
  - Events are dropped when the valid bit is 0 or state==IDLE.
  - Setting an already-set bit is a no-op; events are not counted.
  - Pending bits persist through TAKE and HANDLER.
- States:
  - IDLE -> RUN on START.
  - RUN -> TAKE when any pending bit is set and no START is in the same cycle.
    - Priority: sys > dma > tmr.
    - Latch INT_vector from the winner's vector and last_pc<=PC_pos.
    - INT_req=1 from the next cycle.
  - TAKE: INT_req and INT_vector held stable until INT_ack.
    - On INT_ack: clear the winner's pending bit, INT_req<=0, state<=HANDLER.
    - An ack in the same cycle as INT_req first rises is impossible; INT_ack with INT_req=0 is ignored.
  - HANDLER: timer frozen, no new requests issued (nesting masked). RETR -> RUN.
    - If a pending bit is set on return, the next request is raised the cycle after RETR takes effect.
- Width rules:
  - SCHED_value is truncated or zero-extended to PC_W/TMR_W.
  - Counter never wraps below 0: it reloads at 1.

Test Plan:
- Reset asserted mid-TAKE (INT_req=1) -> all outputs 0 immediately, asynchronously; state IDLE; a later SYS_trap is ignored.
- TMRCFG value=0x0200, START value=5, no other events -> INT_req rises 6 cycles after START is sampled, with INT_vector=0x0200 and last_pc = PC_pos at expiry. INT_ack -> INT_req falls. RETR -> SCHED_out=that PC with valid for 1 cycle, then timer restarts at 5.
- SYSCFG 0x0100, DMACFG 0x0300, START 100; SYS_trap and DMA_done in the same cycle -> first INT_vector=0x0100. After ack and RETR -> second request with INT_vector=0x0300.
- DMA_done with dma_v=0 while running -> no INT_req ever; PC op with PC_pos=0x0042 -> SCHED_out=0x0042, SCHED_out_valid 1 cycle.
- START quantum=4, RTIMER issued every 3 cycles -> no timer interrupt. Quantum=0 -> no timer interrupt for 1000 cycles.
- In HANDLER, timer config valid, 50 cycles pass -> counter unchanged, no INT_req; SYS_trap in HANDLER -> request only after RETR.
